// File: rtl/addsub_pkg.sv
// Shared types and reference model for the 8-bit add/subtract requester slice.
package addsub_pkg;

  localparam int ADDSUB_WIDTH     = 8;
  localparam int SETTLE_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Subtract is B-A (~A+B+1); carry and borrow fall off the top.
  function automatic logic [ADDSUB_WIDTH-1:0] addsub_model(
    input logic [ADDSUB_WIDTH-1:0] a,
    input logic [ADDSUB_WIDTH-1:0] b,
    input logic                    sub
  );
    if (op_t'(sub) == OP_SUB) return b - a;
    else                      return a + b;
  endfunction

endpackage

// File: rtl/addsub_settle_timer.sv
// Load/decrement counter with a zero flag, for pacing multi-cycle datapath requesters.
module addsub_settle_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] loadVal_i,
  input  logic          en_i,
  output logic          done_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)                          count_d = loadVal_i;
    else if (en_i && (count_q != '0))    count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/addsub_requester.sv
// Initiator for the combinational add/sub unit: registers operands, waits SETTLE_CYCLES,
// captures the result and returns it. Optional result checking under ADDSUB_REQ_CHECK_EN.
module addsub_requester
  import addsub_pkg::*;
#(
  parameter int WIDTH         = ADDSUB_WIDTH,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic                 req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic                 rsp_mismatch,
  output logic [WIDTH-1:0]     au_a,
  output logic [WIDTH-1:0]     au_b,
  output logic                 au_sub,
  input  logic [WIDTH-1:0]     au_result,
  output logic [CNT_WIDTH-1:0] txn_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
    $error("addsub_requester: SETTLE_CYCLES must be in 1..15");
  end

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     auA_q, auA_d, auB_q, auB_d;
  logic                 auSub_q, auSub_d;
  logic                 rspValid_q, rspValid_d;
  logic [WIDTH-1:0]     rspResult_q, rspResult_d;
  logic [CNT_WIDTH-1:0] txnCount_q, txnCount_d;
  logic                 timerLoad, timerEn, timerDone;

  addsub_settle_timer #(.CW(SETTLE_CNT_WIDTH)) uTimer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (timerLoad),
    .loadVal_i (SETTLE_CNT_WIDTH'(SETTLE_CYCLES - 1)),
    .en_i      (timerEn),
    .done_o    (timerDone)
  );

`ifdef ADDSUB_REQ_CHECK_EN
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] modelResult;
  assign modelResult = auSub_q ? (auB_q - auA_q) : (auA_q + auB_q);
`endif

  always_comb begin
    state_d     = state_q;
    auA_d       = auA_q;
    auB_d       = auB_q;
    auSub_d     = auSub_q;
    rspValid_d  = rspValid_q;
    rspResult_d = rspResult_q;
    txnCount_d  = txnCount_q;
    timerLoad   = 1'b0;
    timerEn     = 1'b0;
`ifdef ADDSUB_REQ_CHECK_EN
    mismatch_d  = mismatch_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          auA_d     = req_a;
          auB_d     = req_b;
          auSub_d   = req_sub;
          timerLoad = 1'b1;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        timerEn = 1'b1;
        if (timerDone) begin
          rspResult_d = au_result;
          rspValid_d  = 1'b1;
`ifdef ADDSUB_REQ_CHECK_EN
          mismatch_d  = (au_result != modelResult);
`endif
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rspValid_q && rsp_ready) begin
          rspValid_d = 1'b0;
          txnCount_d = txnCount_q + 1'b1;
`ifdef ADDSUB_REQ_CHECK_EN
          mismatch_d = 1'b0;
`endif
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      auA_q       <= '0;
      auB_q       <= '0;
      auSub_q     <= 1'b0;
      rspValid_q  <= 1'b0;
      rspResult_q <= '0;
      txnCount_q  <= '0;
    end else begin
      state_q     <= state_d;
      auA_q       <= auA_d;
      auB_q       <= auB_d;
      auSub_q     <= auSub_d;
      rspValid_q  <= rspValid_d;
      rspResult_q <= rspResult_d;
      txnCount_q  <= txnCount_d;
    end
  end

`ifdef ADDSUB_REQ_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end
  assign rsp_mismatch = mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = rspValid_q;
  assign rsp_result = rspResult_q;
  assign au_a       = auA_q;
  assign au_b       = auB_q;
  assign au_sub     = auSub_q;
  assign txn_count  = txnCount_q;

endmodule

// File: tb/tb_addsub_requester.sv
// Directed bench for addsub_requester: vector table, backpressure, mid-op reset,
// forced-bad-result case and a 256-request back-to-back run on a SETTLE_CYCLES=1 instance.
module tb_addsub_requester;
  import addsub_pkg::*;

  localparam int W = ADDSUB_WIDTH;
`ifdef ADDSUB_REQ_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance with SETTLE_CYCLES=2
  logic         req_valid, req_ready, req_sub, rsp_valid, rsp_ready, rsp_mismatch, au_sub;
  logic [W-1:0] req_a, req_b, rsp_result, au_a, au_b, au_result;
  logic [15:0]  txn_count;
  logic         forceBad;

  // Instance with SETTLE_CYCLES=1
  logic         req_valid1, req_ready1, req_sub1, rsp_valid1, rsp_ready1, rsp_mismatch1, au_sub1;
  logic [W-1:0] req_a1, req_b1, rsp_result1, au_a1, au_b1, au_result1;
  logic [15:0]  txn_count1;

  always_comb begin
    au_result = addsub_model(au_a, au_b, au_sub);
    if (forceBad && au_a == 8'h01 && au_b == 8'h01 && !au_sub) au_result = 8'h00;
  end
  assign au_result1 = addsub_model(au_a1, au_b1, au_sub1);

  addsub_requester #(.WIDTH(W), .SETTLE_CYCLES(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_mismatch(rsp_mismatch),
    .au_a(au_a), .au_b(au_b), .au_sub(au_sub), .au_result(au_result), .txn_count(txn_count)
  );

  addsub_requester #(.WIDTH(W), .SETTLE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_a(req_a1), .req_b(req_b1), .req_sub(req_sub1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1), .rsp_mismatch(rsp_mismatch1),
    .au_a(au_a1), .au_b(au_b1), .au_sub(au_sub1), .au_result(au_result1), .txn_count(txn_count1)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] expResult;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int expCount = 0;
  int cycleCount = 0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
  endtask

  // Ticks until rsp_valid rises; returns the number of edges waited.
  task automatic waitResp(input string name, output int waited);
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      tick();
      waited++;
    end
    if (!rsp_valid) checkOutput({name, " rsp timeout"}, 32'd0, 32'd1);
  endtask

  task automatic runTxn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] expResult, input logic expMismatch);
    int waited;
    checkOutput({name, " req_ready idle"}, 32'(req_ready), 32'd1);
    applyStimulus(a, b, sub);
    tick();
    req_valid = 1'b0;
    checkOutput({name, " au_a"}, 32'(au_a), 32'(a));
    checkOutput({name, " au_b"}, 32'(au_b), 32'(b));
    checkOutput({name, " au_sub"}, 32'(au_sub), 32'(sub));
    checkOutput({name, " req_ready busy"}, 32'(req_ready), 32'd0);
    waitResp(name, waited);
    checkOutput({name, " latency"}, 32'(waited), 32'd2);
    checkOutput({name, " rsp_result"}, 32'(rsp_result), 32'(expResult));
    checkOutput({name, " rsp_mismatch"}, 32'(rsp_mismatch), 32'(expMismatch));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    expCount++;
    checkOutput({name, " rsp_valid clear"}, 32'(rsp_valid), 32'd0);
    checkOutput({name, " req_ready after"}, 32'(req_ready), 32'd1);
    checkOutput({name, " txn_count"}, 32'(txn_count), 32'(expCount));
  endtask

  initial begin
    vec_t vectors[7];
    int   waited;
    bit   sawValid;
    int   lastAccept;
    int   accept;
    int   n;
    logic [W-1:0] ra, rb;
    logic         rs;

    vectors[0] = '{8'h12, 8'h34, 1'b0, 8'h46};
    vectors[1] = '{8'h05, 8'h03, 1'b1, 8'hFE};
    vectors[2] = '{8'hFF, 8'h02, 1'b0, 8'h01};
    vectors[3] = '{8'h10, 8'h30, 1'b1, 8'h20};
    vectors[4] = '{8'h80, 8'h80, 1'b0, 8'h00};
    vectors[5] = '{8'h00, 8'h00, 1'b1, 8'h00};
    vectors[6] = '{8'hFF, 8'h00, 1'b1, 8'h01};

    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0; rsp_ready = 1'b0;
    req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; req_sub1 = 1'b0; rsp_ready1 = 1'b0;
    forceBad = 1'b0;
    #12;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("reset rsp_mismatch", 32'(rsp_mismatch), 32'd0);
    checkOutput("reset au_a", 32'(au_a), 32'd0);
    checkOutput("reset au_b", 32'(au_b), 32'd0);
    checkOutput("reset au_sub", 32'(au_sub), 32'd0);
    checkOutput("reset txn_count", 32'(txn_count), 32'd0);
    #1 rst = 1'b0;
    tick();

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++)
      runTxn($sformatf("vec%0d", i), vectors[i].a, vectors[i].b, vectors[i].sub, vectors[i].expResult, 1'b0);

    $display("[TB] operands hold after transaction");
    tick();
    checkOutput("hold au_a", 32'(au_a), 32'h0FF);
    checkOutput("hold au_sub", 32'(au_sub), 32'd1);

    $display("[TB] backpressure");
    applyStimulus(8'h21, 8'h0F, 1'b1);
    tick();
    req_valid = 1'b0;
    waitResp("bp", waited);
    applyStimulus(8'h40, 8'h02, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d rsp_result", i), 32'(rsp_result), 32'h0EE);
      checkOutput($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
      checkOutput($sformatf("bp%0d au_a", i), 32'(au_a), 32'h021);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    expCount++;
    checkOutput("bp rsp_valid clear", 32'(rsp_valid), 32'd0);
    checkOutput("bp req_ready after", 32'(req_ready), 32'd1);
    checkOutput("bp txn_count", 32'(txn_count), 32'(expCount));
    tick();
    req_valid = 1'b0;
    checkOutput("bp2 au_a", 32'(au_a), 32'h040);
    checkOutput("bp2 au_b", 32'(au_b), 32'h002);
    waitResp("bp2", waited);
    checkOutput("bp2 latency", 32'(waited), 32'd2);
    checkOutput("bp2 rsp_result", 32'(rsp_result), 32'h042);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    expCount++;
    checkOutput("bp2 txn_count", 32'(txn_count), 32'(expCount));

    $display("[TB] reset mid-operation");
    applyStimulus(8'h5A, 8'h11, 1'b1);
    tick();
    req_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst rsp_result", 32'(rsp_result), 32'd0);
    checkOutput("midrst au_a", 32'(au_a), 32'd0);
    checkOutput("midrst au_b", 32'(au_b), 32'd0);
    checkOutput("midrst au_sub", 32'(au_sub), 32'd0);
    checkOutput("midrst txn_count", 32'(txn_count), 32'd0);
    #1 rst = 1'b0;
    expCount = 0;
    sawValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) sawValid = 1'b1;
    end
    checkOutput("midrst no response", 32'(sawValid), 32'd0);
    runTxn("postrst", 8'h07, 8'h09, 1'b0, 8'h10, 1'b0);

    $display("[TB] forced bad unit result");
    forceBad = 1'b1;
    runTxn("bad", 8'h01, 8'h01, 1'b0, 8'h00, CHECK_EN);
    forceBad = 1'b0;
    runTxn("good after bad", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    $display("[TB] back-to-back on SETTLE_CYCLES=1 instance");
    rsp_ready1 = 1'b1;
    lastAccept = 0;
    for (int i = 0; i < 256; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      req_valid1 = 1'b1; req_a1 = ra; req_b1 = rb; req_sub1 = rs;
      n = 0;
      while (!req_ready1 && n < 10) begin
        tick();
        n++;
      end
      tick();
      accept = cycleCount;
      req_valid1 = 1'b0;
      if (i > 0) checkOutput($sformatf("b2b%0d period", i), 32'(accept - lastAccept), 32'd3);
      lastAccept = accept;
      n = 0;
      while (!rsp_valid1 && n < 10) begin
        tick();
        n++;
      end
      checkOutput($sformatf("b2b%0d rsp_result", i), 32'(rsp_result1), 32'(addsub_model(ra, rb, rs)));
      tick();
    end
    checkOutput("b2b txn_count", 32'(txn_count1), 32'd256);
    checkOutput("b2b rsp_mismatch", 32'(rsp_mismatch1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
